// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are consumed DIGIT bits per clock,
// least-significant digit first, through a registered carry, with valid/ready on both sides.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LastCnt = CW'(N - 1);
    localparam logic [WIDTH-1:0] DigMask = WIDTH'({DIGIT{1'b1}});

    if (WIDTH < 2) begin : gen_bad_width
        $error("serial_adder: WIDTH must be >= 2");
    end
    if ((WIDTH % DIGIT) != 0) begin : gen_bad_digit
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_sum;
    logic [31:0]      sh;
    logic [WIDTH-1:0] s_upd;
    logic             ovf_upd;

    // Operands shift right each digit, so the active digit always sits in the low bits and
    // on the last digit its top bit is the operand sign bit.
    always_comb begin
        a_dig   = a_q[DIGIT-1:0];
        b_dig   = b_q[DIGIT-1:0];
        dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT + 1)'(carry_q);
        sh      = 32'(cnt_q) * DIGIT;
        s_upd   = (s_q & ~(DigMask << sh)) | (WIDTH'(dig_sum[DIGIT-1:0]) << sh);
        ovf_upd = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (dig_sum[DIGIT-1] != a_dig[DIGIT-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        // Subtraction folds the two's-complement +1 into the carry-in.
                        carry_q <= sub | cin;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    s_q     <= s_upd;
                    carry_q <= dig_sum[DIGIT];
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        cout_q  <= dig_sum[DIGIT];
                        ovf_q   <= ovf_upd;
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three parameterisations (8/1, 8/4, 4/2) behind a shared stimulus
// port, table vectors, reset and backpressure sequences, random and exhaustive sweeps.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_ready = 1'b0;
    int         sel = 0;

    int n_pass = 0;
    int n_total = 0;

    logic       iv0, ir0, ov0, c0, o0;
    logic [7:0] s0;
    logic       iv1, ir1, ov1, c1, o1;
    logic [7:0] s1;
    logic       iv2, ir2, ov2, c2, o2;
    logic [3:0] s2;

    logic       obs_in_ready, obs_out_valid, obs_cout, obs_ovf;
    logic [7:0] obs_s;

    always #5 clk = ~clk;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .cin(cin),
        .sub(sub), .out_valid(ov0), .out_ready(out_ready), .s(s0), .cout(c0), .ovf(o0)
    );
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .cin(cin),
        .sub(sub), .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(c1), .ovf(o1)
    );
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a[3:0]), .b(b[3:0]),
        .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .s(s2), .cout(c2),
        .ovf(o2)
    );

    always_comb begin
        obs_in_ready  = ir0;
        obs_out_valid = ov0;
        obs_s         = s0;
        obs_cout      = c0;
        obs_ovf       = o0;
        if (sel == 1) begin
            obs_in_ready  = ir1;
            obs_out_valid = ov1;
            obs_s         = s1;
            obs_cout      = c1;
            obs_ovf       = o1;
        end else if (sel == 2) begin
            obs_in_ready  = ir2;
            obs_out_valid = ov2;
            obs_s         = {4'b0000, s2};
            obs_cout      = c2;
            obs_ovf       = o2;
        end
    end

    task automatic check(input string tag, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s/%s: got %0h, expected %0h", tag, name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int lat_of(input int sl);
        return (sl == 0) ? 8 : 2;
    endfunction

    function automatic int width_of(input int sl);
        return (sl == 2) ? 4 : 8;
    endfunction

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic void model(input int w, input int av, input int bv, input bit ci,
                                  input bit su, output logic [7:0] es, output logic ec,
                                  output logic eo);
        int mask, ua, ub, tot, sa, sb, st;
        mask = (1 << w) - 1;
        ua   = av & mask;
        ub   = bv & mask;
        tot  = su ? ua + ((~ub) & mask) + 1 : ua + ub + int'(ci);
        es   = 8'(tot & mask);
        ec   = 1'((tot >> w) & 1);
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        st   = su ? sa - sb : sa + sb + int'(ci);
        eo   = (st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1)));
    endfunction

    task automatic run_op(input int sl, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic su, input logic [7:0] es,
                          input logic ec, input logic eo, input int hold, input string tag);
        int n;
        int lat;
        sel = sl;
        @(negedge clk);
        n = 0;
        while (!obs_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, "in_ready", 32'(obs_in_ready), 32'd1);
        a = av; b = bv; cin = ci; sub = su; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: they must not be sampled after the accept edge.
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!obs_out_valid && lat < 64) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        check(tag, "latency", 32'(lat), 32'(lat_of(sl)));
        check(tag, "s", 32'(obs_s), 32'(es));
        check(tag, "cout", 32'(obs_cout), 32'(ec));
        check(tag, "ovf", 32'(obs_ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check(tag, "hold", {20'd0, obs_out_valid, obs_in_ready, obs_s, obs_cout, obs_ovf},
                  {20'd0, 1'b1, 1'b0, es, ec, eo});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check(tag, "retire", {20'd0, obs_out_valid, obs_in_ready, obs_s, obs_cout, obs_ovf},
              {20'd0, 1'b0, 1'b1, es, ec, eo});
    endtask

    typedef struct {
        int         sl;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic       su;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] es;
        logic       ec, eo;
        int         sl;
        logic [7:0] av, bv;
        logic       ci, su;

        vecs[0] = '{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1, 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{2, 8'h07, 8'h01, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1};

        #1;
        check("reset", "state", {20'd0, obs_out_valid, obs_in_ready, obs_s, obs_cout, obs_ovf},
              {20'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].sl, vecs[i].av, vecs[i].bv, vecs[i].ci, vecs[i].su, vecs[i].es,
                   vecs[i].ec, vecs[i].eo, (i == 0) ? 5 : 1, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-RUN, after a result that left cout set.
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, "pre_rst");
        sel = 0;
        @(negedge clk);
        a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid", "async", {20'd0, obs_out_valid, obs_in_ready, obs_s, obs_cout, obs_ovf},
              {20'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid", "discard", {30'd0, obs_out_valid, obs_in_ready}, 32'd1);
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0, "post_rst");

        for (int i = 0; i < 200; i++) begin
            sl = int'($urandom_range(0, 1));
            av = 8'($urandom); bv = 8'($urandom); ci = 1'($urandom); su = 1'($urandom);
            model(width_of(sl), int'(av), int'(bv), ci, su, es, ec, eo);
            run_op(sl, av, bv, ci, su, es, ec, eo, int'($urandom_range(0, 2)),
                   $sformatf("rnd%0d", i));
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int m = 0; m < 4; m++) begin
                    ci = m[0]; su = m[1];
                    model(4, x, y, ci, su, es, ec, eo);
                    run_op(2, 8'(x), 8'(y), ci, su, es, ec, eo, int'($urandom_range(0, 3)),
                           $sformatf("ex_%0h_%0h_%0d", x, y, m));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor and the sequential successor to the single-bit full adder.
- Accepts two WIDTH-bit operands through a valid/ready handshake and processes them DIGIT bits per clock, least-significant digit first, through a registered carry.
- Returns sum, carry-out and signed overflow on an output valid/ready handshake.
- Intended for area-constrained datapaths where a WIDTH-bit ripple adder is too large.

Parameters:
- WIDTH, 8: operand and sum width in bits. Must be >= 2.
- DIGIT, 1: bits processed per cycle. WIDTH % DIGIT must be 0; elaboration fails otherwise.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operands and mode are valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in (add mode only).
- sub, input, 1: 0 = add, 1 = subtract.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- s, output, WIDTH: sum or difference.
- cout, output, 1: carry-out; in subtract mode 1 = no borrow.
- ovf, output, 1: two's-complement signed overflow.

Behaviour:
- N = WIDTH/DIGIT digit cycles per operation.
- FSM states: IDLE, RUN, DONE.
- Reset (asynchronous, any state, including mid-RUN or DONE): state = IDLE, s = 0, cout = 0, ovf = 0, out_valid = 0, digit counter = 0, carry register = 0. Any in-flight operation is discarded with no result.
- in_ready = 1 iff state == IDLE; it is combinational from state only.
- out_valid = 1 iff state == DONE.
- Accept: on a rising edge with in_valid && in_ready:
  - latch a.
  - latch b, or ~b when sub = 1.
  - carry register <= sub ? 1 : cin.
  - counter <= 0, state -> RUN.
  - a, b, cin and sub are not sampled at any other time.
- RUN, each edge, digit i = counter:
  - {c, d} = A[i] + B'[i] + carry, where d is DIGIT bits wide.
  - d is written into bits [i*DIGIT +: DIGIT] of the s register; carry <= c; counter++.
  - On the edge processing i = N-1, the final carry goes to cout, ovf = (a[W-1] == B'[W-1]) && (s[W-1] != a[W-1]), and state -> DONE.
- Latency: out_valid is high after exactly N rising edges following the accepting edge. For WIDTH=8, DIGIT=1 that is 8 edges; for DIGIT=4 it is 2 edges; for DIGIT=WIDTH it is 1 edge.
- DONE:
  - s, cout and ovf hold stable while out_valid && !out_ready, for any number of cycles.
  - On an edge with out_valid && out_ready, state -> IDLE and out_valid drops.
  - s, cout and ovf keep their last values in IDLE and RUN, so intermediate s bits are visible during RUN. Consumers must qualify outputs with out_valid.
- No overlap: a new operation cannot be accepted in the same edge as result retirement; in_ready rises the cycle after.
- in_valid while the block is busy is ignored; the producer must hold it until in_ready.
- cin is ignored when sub = 1.
- Arithmetic is modulo 2^WIDTH; cout carries the (WIDTH+1)th bit.
- Result must equal the single-cycle model: {cout, s} = a + (sub ? ~b + 1 : b + cin), with the +1 folded into the carry-in.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A, b=0x3C, cin=0 -> s=0x96, cout=0, ovf=1. out_valid rises exactly 8 edges after the accept edge.
- WIDTH=8, DIGIT=1, add a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> s=0x80, cout=0, ovf=1.
- WIDTH=8, DIGIT=4, subtract:
  - a=0x10, b=0x20 -> s=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01 -> s=0x7F, cout=1, ovf=1.
  - Latency is 2 edges in both cases.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> s, cout, ovf, out_valid stable and in_ready=0. Assert out_ready -> IDLE next edge, in_ready=1. in_valid pulsed during RUN/DONE is ignored, and the result matches the first operands.
- Reset asserted asynchronously mid-RUN (counter=3) -> out_valid, s, cout, ovf = 0 and in_ready=1 immediately, without waiting for a clock edge. After release, a fresh operation 0x01+0x01 returns s=0x02.
- WIDTH=4, DIGIT=2, exhaustive over all a, b, cin, sub (1024 cases) with randomised out_ready delays -> every result matches the single-cycle model using === checks on s, cout, ovf.
